// File: rtl/conv_win_ctrl.sv
// 3x3 convolution window controller.
// Streams 3-pixel columns per band and flags each complete window.
module conv_win_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_width,
    input  logic [7:0] cfg_bands,
    input  logic       col_valid,
    output logic       col_ready,
    input  logic       mac_stall,
    output logic       buf_shift,
    output logic       win_valid,
    output logic [7:0] win_x,
    output logic [7:0] win_y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_w;
    logic [7:0] r_b;
    logic [7:0] r_col;
    logic [7:0] r_band;
    logic       r_win_valid;
    logic [7:0] r_win_x;
    logic [7:0] r_win_y;
    logic       w_shift;
    logic       w_last_col;
    logic       w_last_band;
    logic       w_legal;

    assign col_ready   = (r_state == S_RUN) & ~mac_stall;
    assign w_shift     = col_valid & col_ready;
    assign buf_shift   = w_shift;
    assign w_last_col  = (r_col == r_w - 8'd1);
    assign w_last_band = (r_band == r_b - 8'd1);
    assign w_legal     = (cfg_width >= 8'd3) && (cfg_bands != 8'd0);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign win_valid   = r_win_valid;
    assign win_x       = r_win_x;
    assign win_y       = r_win_y;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: a band ends on its last column transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = w_legal ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (w_shift && w_last_col)
                    w_next = w_last_band ? S_DONE : S_NEXT;
            end
            S_NEXT:  w_next = S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Config latch and column/band counters; counters saturate, never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w    <= 8'd0;
            r_b    <= 8'd0;
            r_col  <= 8'd0;
            r_band <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w    <= cfg_width;
                        r_b    <= cfg_bands;
                        r_col  <= 8'd0;
                        r_band <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_shift && !w_last_col) r_col <= r_col + 8'd1;
                end
                S_NEXT: begin
                    r_col  <= 8'd0;
                    r_band <= r_band + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Window flag pulses after the 3rd and later transfers of a band.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_x     <= 8'd0;
            r_win_y     <= 8'd0;
        end else begin
            r_win_valid <= w_shift && (r_col >= 8'd2);
            if (w_shift && (r_col >= 8'd2)) begin
                r_win_x <= r_col - 8'd2;
                r_win_y <= r_band;
            end
        end
    end

endmodule

// File: tb/tb_conv_win_ctrl.sv
// Directed bench for conv_win_ctrl.
// Expected windows are queued at frame start and popped on win_valid.
module tb_conv_win_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_width;
    logic [7:0] cfg_bands;
    logic       col_valid;
    logic       col_ready;
    logic       mac_stall;
    logic       buf_shift;
    logic       win_valid;
    logic [7:0] win_x;
    logic [7:0] win_y;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int n_xfer, n_win, n_done, n_ready, n_gap;
    logic s_ready, s_shift;
    logic [15:0] q[$];

    conv_win_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_width (cfg_width),
        .cfg_bands (cfg_bands),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .mac_stall (mac_stall),
        .buf_shift (buf_shift),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_xfer  = 0;
        n_win   = 0;
        n_done  = 0;
        n_ready = 0;
        n_gap   = 0;
    endtask

    // One clock: sample handshake before the edge, outputs after it.
    task automatic cyc();
        logic [15:0] e;
        #1;
        s_ready = col_ready;
        s_shift = buf_shift;
        if (buf_shift) n_xfer++;
        if (col_ready) n_ready++;
        if (busy && !col_ready && !done && !mac_stall) n_gap++;
        @(posedge clk);
        #1;
        if (win_valid) begin
            n_win++;
            if (q.size() == 0) begin
                chk("win_extra", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("win_yx", {16'd0, win_y, win_x}, {16'd0, e});
            end
        end
        if (done) n_done++;
    endtask

    // mode 0 plain, 1 stall after 2nd transfer, 2 toggle valid, 3 restart attempt
    task automatic run_frame(input int w, input int b, input int mode);
        int k;
        int stall_left;
        bit legal;
        legal = (w >= 3) && (b >= 1);
        clr_counts();
        q.delete();
        if (legal)
            for (int y = 0; y < b; y++)
                for (int x = 0; x < w - 2; x++)
                    q.push_back({y[7:0], x[7:0]});
        start     = 1'b1;
        cfg_width = w[7:0];
        cfg_bands = b[7:0];
        col_valid = 1'b1;
        mac_stall = 1'b0;
        cyc();
        start     = 1'b0;
        cfg_width = 8'd0;
        cfg_bands = 8'd0;
        k = 0;
        stall_left = 3;
        while (!done && k < 2000) begin
            start = 1'b0;
            mac_stall = 1'b0;
            col_valid = 1'b1;
            if (mode == 1 && n_xfer == 2 && stall_left > 0) begin
                mac_stall = 1'b1;
                stall_left--;
            end
            if (mode == 2) col_valid = (k % 2 == 0);
            if (mode == 3 && k == 3) begin
                start = 1'b1;
                cfg_width = 8'd10;
                cfg_bands = 8'd3;
            end
            cyc();
            if (mac_stall) begin
                chk("stall_ready", {31'd0, s_ready}, 32'd0);
                chk("stall_xfer", n_xfer, 32'd2);
            end
            if (mode == 2 && !col_valid)
                chk("tog_noshift", {31'd0, s_shift}, 32'd0);
            k++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("done_after_xfer", {31'd0, s_shift}, {31'd0, legal});
        chk("xfers", n_xfer, legal ? w * b : 0);
        chk("windows", n_win, legal ? (w - 2) * b : 0);
        chk("q_empty", q.size(), 32'd0);
        chk("band_gap", n_gap, legal ? b - 1 : 0);
        if (!legal) chk("never_ready", n_ready, 32'd0);
        if (mode == 1) chk("stall_used", stall_left, 32'd0);
        col_valid = 1'b0;
        cyc();
        chk("done_1cyc", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("done_count", n_done, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_width = 8'd0;
        cfg_bands = 8'd0;
        col_valid = 1'b1;
        mac_stall = 1'b0;
        clr_counts();
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, col_ready}, 32'd0);
        chk("rst_shift", {31'd0, buf_shift}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_win",   {31'd0, win_valid}, 32'd0);
        chk("rst_wxy",   {16'd0, win_y, win_x}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(5, 2, 0);
        run_frame(4, 1, 1);
        run_frame(2, 3, 0);
        run_frame(5, 0, 0);
        run_frame(5, 1, 3);
        run_frame(8, 1, 2);

        // Abort mid-frame: W=6, B=3, reset after 3rd transfer of band 1.
        clr_counts();
        q.delete();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                q.push_back({y[7:0], x[7:0]});
        start     = 1'b1;
        cfg_width = 8'd6;
        cfg_bands = 8'd3;
        col_valid = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 100 && n_xfer < 9; k++) cyc();
        chk("abort_xfer", n_xfer, 32'd9);
        chk("abort_wins", n_win, 32'd5);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, col_ready}, 32'd0);
        chk("abort_shift", {31'd0, buf_shift}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_win",   {31'd0, win_valid}, 32'd0);
        chk("abort_wxy",   {16'd0, win_y, win_x}, 32'd0);
        q.delete();
        clr_counts();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk("abort_nodone", n_done, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_noxfer", n_xfer, 32'd0);
        run_frame(3, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_win_ctrl.md
CONV_WIN_CTRL -- requirements
Module: conv_win_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all flops on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  one-cycle pulse; begins a frame from IDLE.
REQ-004 SHALL have port: cfg_width  in  8  columns per band, W; legal 3..255.
REQ-005 SHALL have port: cfg_bands  in  8  bands per frame, B; legal 1..255.
REQ-006 SHALL have port: col_valid  in  1  upstream 24-bit column (3 pixels) available.
REQ-007 SHALL have port: col_ready  out  1  controller accepts a column this cycle.
REQ-008 SHALL have port: mac_stall  in  1  downstream MAC cannot take a window.
REQ-009 SHALL have port: buf_shift  out  1  shift enable to the 3-column window buffer.
REQ-010 SHALL have port: win_valid  out  1  buffer holds a new valid 3x3 window.
REQ-011 SHALL have port: win_x  out  8  leftmost column index of the current window.
REQ-012 SHALL have port: win_y  out  8  band index of the current window.
REQ-013 SHALL have port: busy  out  1  frame in progress.
REQ-014 SHALL have port: done  out  1  one-cycle frame-complete pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, NEXT, DONE.
REQ-016 IDLE: start=1 SHALL latch cfg_width/cfg_bands into internal registers; next state RUN if W>=3 and B>=1, else DONE.
REQ-017 Config inputs SHALL be ignored outside the start cycle; start SHALL be ignored when state is not IDLE.
REQ-018 col_ready SHALL equal (state==RUN) & ~mac_stall, combinationally.
REQ-019 buf_shift SHALL equal col_valid & col_ready; a transfer occurs only when buf_shift=1.
REQ-020 col_cnt (8 bits) SHALL count transfers in the current band, 0 after RUN entry, incremented per transfer.
REQ-021 On the transfer with col_cnt==W-1: if band_cnt==B-1, next state DONE; else next state NEXT.
REQ-022 NEXT SHALL last exactly one cycle with col_ready=0, clear col_cnt, increment band_cnt, then go to RUN.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; done SHALL be 1 only while in DONE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 win_valid SHALL be registered: 1 in the cycle after a transfer with col_cnt>=2 (before increment), else 0; exactly one pulse per window.
REQ-026 win_x SHALL be registered with col_cnt-2 and win_y with band_cnt on the same edge that sets win_valid; both hold otherwise.
REQ-027 Windows per band SHALL be W-2; windows per frame (W-2)*B; first window of each band after its 3rd transfer only.
REQ-028 mac_stall=1 SHALL only pause transfers; no counter or state change while stalled in RUN.
REQ-029 col_valid=0 in RUN SHALL hold all state; no timeout.
REQ-030 Counters SHALL never wrap: col_cnt<=W-1, band_cnt<=B-1.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, col_cnt=0, band_cnt=0, latched config=0, win_valid=0, win_x=0, win_y=0, done=0.
REQ-032 With rst=1: col_ready=0, buf_shift=0, busy=0.
REQ-033 rst asserted mid-frame SHALL abort the frame with no done pulse; after release, a new start SHALL be required.

Verification
REQ-034 W=5, B=2, col_valid=1, mac_stall=0 -> per band 5 transfers, win_valid 3 pulses with win_x 0,1,2; win_y 0 then 1; col_ready=0 for exactly 1 cycle between bands; done pulses 1 cycle after the 10th transfer.
REQ-035 W=4, B=1, mac_stall=1 for 3 cycles after 2nd transfer -> col_ready=0, no transfers during stall; exactly 2 windows (win_x 0,1); done once.
REQ-036 start with cfg_width=2, B=3 -> DONE next cycle, done=1 for 1 cycle, col_ready never 1, zero windows; same for B=0.
REQ-037 start pulsed while busy with different cfg -> ignored; frame completes with the original W/B window count.
REQ-038 rst pulsed after 3rd transfer of band 1 (W=6, B=3) -> all outputs 0 immediately, busy=0, no done; restart with W=3, B=1 yields 1 window (win_x 0, win_y 0).
REQ-039 col_valid toggling every other cycle, W=8, B=1 -> transfers only on col_valid=1 cycles, 6 windows, win_x 0..5 in order.
